// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/accumulate unit: op codes, FSM states, default width.
package hilo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MADD  = 3'b011;
    localparam logic [2:0] OP_MSUB  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // MULTU is the only multiply-class op that treats its operands as unsigned.
    function automatic logic is_signed_op(input logic [2:0] op);
        return op != OP_MULTU;
    endfunction

endpackage

// File: rtl/iter_mult_datapath.sv
// Iterative unsigned shift-add multiplier: retires BITS_PER_CYCLE multiplier bits per step.
module iter_mult_datapath #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    // Add the shifted multiplicand once per set bit of the current multiplier digit.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (mplier_q[i]) begin
                acc_d = acc_d + (mcand_q << i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            acc_q    <= '0;
            mplier_q <= b_mag;
            cnt_q    <= CNT_INIT;
        end else if (step) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

    assign product = acc_q;
    assign last    = (cnt_q == '0);

endmodule

// File: rtl/hilo_mult_unit.sv
// Multi-cycle multiply/accumulate unit owning the architectural HI/LO pair.
module hilo_mult_unit
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_t             state_q;
    logic [2:0]         op_q;
    logic               sign_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               issue;
    logic               issue_mul;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               dp_step;
    logic               dp_last;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_signed;
    logic [2*WIDTH-1:0] hilo;
    logic [2*WIDTH-1:0] result;

    // Start is only looked at while idle; Flush in the same cycle squashes it.
    assign issue     = Start && !Flush && (state_q == IDLE);
    assign issue_mul = issue && is_mul_op(Op);
    assign op_signed = is_signed_op(Op);

    assign a_mag = (op_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign b_mag = (op_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;

    assign dp_step = (state_q == RUN);

    iter_mult_datapath #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_datapath (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .load    (issue_mul),
        .step    (dp_step),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .product (product),
        .last    (dp_last)
    );

    // Finish step: apply the sign, then accumulate against the committed HI/LO.
    always_comb begin
        prod_signed = sign_q ? (~product + 1'b1) : product;
        hilo        = {hi_q, lo_q};
        case (op_q)
            OP_MADD: result = hilo + prod_signed;
            OP_MSUB: result = hilo - prod_signed;
            default: result = prod_signed;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        case (Op)
                            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                                op_q    <= Op;
                                sign_q  <= op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (Flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (dp_last) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!Flush) begin
                        done_q <= 1'b1;
                        hi_q   <= result[2*WIDTH-1:WIDTH];
                        lo_q   <= result[WIDTH-1:0];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Multi-cycle multiply/accumulate unit that owns the architectural HI/LO register pair.
- It is the producer side of the ALU's Hi_in/Lo_in interface: the ALU (mfhi/mflo) reads HI/LO from here, and the pipeline issues mult, multu, madd, msub, mthi and mtlo to here.
- The unit is iterative. It asserts Busy so the hazard unit stalls any HI/LO consumer or new HI/LO op until the result is committed.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; legal values 1, 2, 4. N = WIDTH/BITS_PER_CYCLE.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  issue strobe; sampled only when Busy=0.
- Op  in  3  operation code (encoding in package).
- A  in  WIDTH  rs operand.
- B  in  WIDTH  rt operand.
- Flush  in  1  abort the in-flight op (branch/exception squash).
- Busy  out  1  op in flight; HI/LO not yet valid.
- Done  out  1  one-cycle pulse; new HI/LO are visible this cycle.
- Hi  out  WIDTH  registered HI; feeds ALU Hi_in.
- Lo  out  WIDTH  registered LO; feeds ALU Lo_in.

Behaviour:
- Reset (async, Rst_n=0): state=IDLE; Hi=0, Lo=0, Busy=0, Done=0; the iteration counter and accumulator are cleared. Reset mid-operation discards the op with no commit.
- Op encoding:
  - 000 NOP
  - 001 MULT (signed)
  - 010 MULTU
  - 011 MADD: {Hi,Lo} += signed A*B
  - 100 MSUB: {Hi,Lo} -= signed A*B
  - 101 MTHI
  - 110 MTLO
  - 111 reserved, treated as NOP
- MTHI/MTLO/NOP while IDLE: single cycle. Hi (or Lo) is set to A at the sampling edge. No Busy, no Done.
- States:
  - IDLE: Start && !Flush with a multiply-class op goes to RUN.
  - RUN: lasts exactly N cycles, then goes to FINISH.
  - FINISH: lasts 1 cycle, then goes to IDLE.
- At Start, the unit latches the operand magnitudes and the result sign. The sign is A[31]^B[31] for signed ops and 0 for MULTU.
- RUN: radix-2^BITS_PER_CYCLE shift-add on the magnitudes into a 2*WIDTH-bit product. The counter counts N-1 down to 0.
- FINISH:
  - Negate the product if the sign is set.
  - For MADD/MSUB, add or subtract the product against the full 64-bit {Hi,Lo}. The carry/borrow propagates from LO into HI, and the result wraps modulo 2^64.
  - Write Hi/Lo at the end of FINISH.
- Timing with Start sampled at edge 0: Busy=1 from cycle 1 through cycle N+1. Done=1 and new Hi/Lo are visible in cycle N+2, where Busy=0. For the default parameters this is 34 cycles.
- Start while Busy=1 is ignored. The hazard unit must stall the issuing instruction, and an MTHI/MTLO presented while busy is also ignored.
- Flush:
  - In RUN or FINISH: return to IDLE at the next edge with Busy=0, no Done, and Hi/Lo unchanged.
  - Same cycle as Start: Flush wins and nothing is issued or written.
- Done and a new Start in the same cycle are legal: the new op is accepted and Busy=1 next cycle. Back-to-back MADDs accumulate correctly because FINISH reads the committed Hi/Lo.
- Hi/Lo change only at a FINISH commit or an MTHI/MTLO write. They are never combinationally forwarded.

Decomposition:
- Package hilo_pkg holds:
  - The op-code localparams: OP_NOP, OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO.
  - The state encoding: IDLE, RUN, FINISH.
  - The default WIDTH.
- Sub-module iter_mult_datapath owns the magnitude registers, the shift-add accumulator and the counter. It has load/step inputs and a last output.
- The top level owns the FSM, the sign/accumulate finish step and the HI/LO registers.

Test Plan:
- MULT A=0xFFFFFFFF, B=0x00000002 -> Done in cycle 34; Hi=0xFFFFFFFF, Lo=0xFFFFFFFE; Busy high for cycles 1..33.
- MULTU with the same operands -> Hi=0x00000001, Lo=0xFFFFFFFE. MULT A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000.
- Carry propagation: MTHI A=0, MTLO A=0xFFFFFFFF, then MADD A=1, B=1 -> Hi=0x00000001, Lo=0x00000000.
- MSUB from Hi=Lo=0 with A=2, B=3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
- MULT issued, then at cycle 5 Start+MTHI A=0x1234 -> ignored (Hi unaffected). Flush at cycle 10 -> Busy=0 at cycle 11, Done never pulses, Hi/Lo keep their prior values.
- Rst_n pulsed low at cycle 20 of a MADD -> Hi=Lo=0, Busy=0 immediately. A MULT 3*5 issued after release gives Hi=0, Lo=15.
